// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Shares one external combinational ALU between two requesters. An IDLE /
//   EXEC / RESP state machine accepts one operation at a time, drives the
//   registered operands to the ALU for a single EXEC cycle, captures the ALU
//   result and flags, and holds them on a response channel until consumed.
//   The block performs no arithmetic; data passes through unmodified.
//
// Configuration:
//   ALU_ARB_FIXED_PRIO_EN  - when defined, requester 0 always wins a tie and
//                            no last-grant state exists. When undefined,
//                            ties are resolved round-robin.
//
// Ports:
//   clk_i          clock, all state updates on its rising edge
//   rst_ni         asynchronous active-low reset
//   reqN_valid_i   requester N has an operation pending (N = 0, 1)
//   reqN_r1_i      first operand of requester N
//   reqN_r2_i      second operand of requester N
//   reqN_op_i      opcode of requester N
//   reqN_ready_o   requester N is accepted this cycle (combinational)
//   alu_r1_o       registered first operand to the ALU
//   alu_r2_o       registered second operand to the ALU
//   alu_op_o       registered opcode to the ALU
//   alu_out_i      combinational ALU result
//   alu_flags_i    combinational ALU flags
//   rsp_valid_o    response available
//   rsp_id_o       index of the requester that owns the response
//   rsp_data_o     captured ALU result
//   rsp_flags_o    captured ALU flags
//   rsp_ready_i    consumer takes the response
//   busy_o         high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned FLAG_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic              req0_valid_i,
  input  logic [DATA_W-1:0] req0_r1_i,
  input  logic [DATA_W-1:0] req0_r2_i,
  input  logic [OP_W-1:0]   req0_op_i,
  output logic              req0_ready_o,

  input  logic              req1_valid_i,
  input  logic [DATA_W-1:0] req1_r1_i,
  input  logic [DATA_W-1:0] req1_r2_i,
  input  logic [OP_W-1:0]   req1_op_i,
  output logic              req1_ready_o,

  output logic [DATA_W-1:0] alu_r1_o,
  output logic [DATA_W-1:0] alu_r2_o,
  output logic [OP_W-1:0]   alu_op_o,
  input  logic [DATA_W-1:0] alu_out_i,
  input  logic [FLAG_W-1:0] alu_flags_i,

  output logic              rsp_valid_o,
  output logic              rsp_id_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [FLAG_W-1:0] rsp_flags_o,
  input  logic              rsp_ready_i,

  output logic              busy_o
);

  // FSM encoding; the 2'd3 code is never entered.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state_q,    state_d;
  logic [DATA_W-1:0] alu_r1_q,   alu_r1_d;
  logic [DATA_W-1:0] alu_r2_q,   alu_r2_d;
  logic [OP_W-1:0]   alu_op_q,   alu_op_d;
  logic              rsp_id_q,   rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;

  logic in_idle;
  logic grant_idx;
  logic handshake;

  assign in_idle = (state_q == IDLE);

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Fixed priority: requester 0 wins whenever it is valid, so requester 1
  // is chosen only when requester 0 is idle.
  always_comb begin
    grant_idx = ~req0_valid_i;
  end
`else
  logic last_grant_q, last_grant_d;

  // Round-robin: on a tie the requester that did not win last time is
  // chosen; a lone valid requester wins regardless of history.
  always_comb begin
    grant_idx = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grant_idx = ~last_grant_q;
    end else begin
      grant_idx = req1_valid_i;
    end
  end

  // History is only updated on an actual handshake, so requests that are
  // withdrawn before being accepted leave the arbitration order untouched.
  always_comb begin
    last_grant_d = last_grant_q;
    if (handshake) begin
      last_grant_d = grant_idx;
    end
  end

  // Reset value 1 makes requester 0 the first winner of a tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Ready is gated by the grant index so at most one ready is ever high,
  // and by IDLE so nothing is accepted while an operation is in flight.
  assign req0_ready_o = in_idle & req0_valid_i & ~grant_idx;
  assign req1_ready_o = in_idle & req1_valid_i &  grant_idx;
  assign handshake    = req0_ready_o | req1_ready_o;

  // Next-state and datapath load logic. Every register holds by default;
  // operands load only on a handshake and the response only at the end of
  // EXEC, which keeps the ALU inputs stable in IDLE and RESP.
  always_comb begin
    state_d     = state_q;
    alu_r1_d    = alu_r1_q;
    alu_r2_d    = alu_r2_q;
    alu_op_d    = alu_op_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;

    case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d  = EXEC;
          rsp_id_d = grant_idx;
          if (grant_idx) begin
            alu_r1_d = req1_r1_i;
            alu_r2_d = req1_r2_i;
            alu_op_d = req1_op_i;
          end else begin
            alu_r1_d = req0_r1_i;
            alu_r2_d = req0_r2_i;
            alu_op_d = req0_op_i;
          end
        end
      end

      EXEC: begin
        state_d     = RESP;
        rsp_data_d  = alu_out_i;
        rsp_flags_d = alu_flags_i;
      end

      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state registers share the asynchronous reset so that a reset in
  // EXEC or RESP discards the operation and clears the response at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      alu_r1_q    <= '0;
      alu_r2_q    <= '0;
      alu_op_q    <= '0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      alu_r1_q    <= alu_r1_d;
      alu_r2_q    <= alu_r2_d;
      alu_op_q    <= alu_op_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign alu_r1_o    = alu_r1_q;
  assign alu_r2_o    = alu_r2_q;
  assign alu_op_o    = alu_op_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_flags_o = rsp_flags_q;

  // rsp_valid is decoded from the registered state, so it is glitch-free
  // and drops together with the state on reset.
  assign rsp_valid_o = (state_q == RESP);
  assign busy_o      = ~in_idle;

  // Protocol invariants of the arbiter.
  aOneReady: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(req0_ready_o && req1_ready_o));

  aNoReadyWhenBusy: assert property (@(posedge clk_i) disable iff (!rst_ni)
    busy_o |-> !(req0_ready_o || req1_ready_o));

  aLegalState: assert property (@(posedge clk_i) disable iff (!rst_ni)
    state_q != 2'd3);

  aRspHold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rsp_valid_o && !rsp_ready_i) |=>
      (rsp_valid_o && $stable(rsp_data_o) && $stable(rsp_id_o) &&
       $stable(rsp_flags_o)));

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed testbench for alu_arbiter. A small combinational ALU model sits
// on the ALU port (op 0 ADD, 1 SUB, 2 AND, 3 XOR; flags {Z, N, C, V}).
// Expected results are hand-computed constants. Define ALU_ARB_FIXED_PRIO_EN
// for both files to exercise the fixed-priority build.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 4;

  logic              clk_i;
  logic              rst_ni;
  logic              req0_valid_i, req1_valid_i;
  logic [DATA_W-1:0] req0_r1_i, req0_r2_i, req1_r1_i, req1_r2_i;
  logic [OP_W-1:0]   req0_op_i, req1_op_i;
  logic              req0_ready_o, req1_ready_o;
  logic [DATA_W-1:0] alu_r1_o, alu_r2_o;
  logic [OP_W-1:0]   alu_op_o;
  logic [DATA_W-1:0] alu_out_i;
  logic [FLAG_W-1:0] alu_flags_i;
  logic              rsp_valid_o, rsp_id_o;
  logic [DATA_W-1:0] rsp_data_o;
  logic [FLAG_W-1:0] rsp_flags_o;
  logic              rsp_ready_i;
  logic              busy_o;

  int nVec = 0;
  int nErr = 0;

  alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W), .FLAG_W(FLAG_W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req0_valid_i (req0_valid_i),
    .req0_r1_i    (req0_r1_i),
    .req0_r2_i    (req0_r2_i),
    .req0_op_i    (req0_op_i),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (req1_valid_i),
    .req1_r1_i    (req1_r1_i),
    .req1_r2_i    (req1_r2_i),
    .req1_op_i    (req1_op_i),
    .req1_ready_o (req1_ready_o),
    .alu_r1_o     (alu_r1_o),
    .alu_r2_o     (alu_r2_o),
    .alu_op_o     (alu_op_o),
    .alu_out_i    (alu_out_i),
    .alu_flags_i  (alu_flags_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_id_o     (rsp_id_o),
    .rsp_data_o   (rsp_data_o),
    .rsp_flags_o  (rsp_flags_o),
    .rsp_ready_i  (rsp_ready_i),
    .busy_o       (busy_o)
  );

  // 10 ns clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Environment ALU: purely combinational on the registered DUT operands.
  logic [DATA_W:0] aluWide;
  logic            aluV;
  always_comb begin
    aluWide = '0;
    aluV    = 1'b0;
    case (alu_op_o)
      4'd0: begin
        aluWide = {1'b0, alu_r1_o} + {1'b0, alu_r2_o};
        aluV    = (alu_r1_o[DATA_W-1] == alu_r2_o[DATA_W-1]) &&
                  (aluWide[DATA_W-1] != alu_r1_o[DATA_W-1]);
      end
      4'd1: begin
        aluWide = {1'b0, alu_r1_o} - {1'b0, alu_r2_o};
        aluV    = (alu_r1_o[DATA_W-1] != alu_r2_o[DATA_W-1]) &&
                  (aluWide[DATA_W-1] != alu_r1_o[DATA_W-1]);
      end
      4'd2:    aluWide = {1'b0, alu_r1_o & alu_r2_o};
      4'd3:    aluWide = {1'b0, alu_r1_o ^ alu_r2_o};
      default: aluWide = {1'b0, alu_r1_o};
    endcase
    alu_out_i   = aluWide[DATA_W-1:0];
    alu_flags_i = {(aluWide[DATA_W-1:0] == '0), aluWide[DATA_W-1],
                   aluWide[DATA_W], aluV};
  end

  // Advance to 1 ns after the next rising edge.
  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic [15:0] a0,
                               input logic [15:0] b0, input logic [3:0] o0,
                               input logic v1, input logic [15:0] a1,
                               input logic [15:0] b1, input logic [3:0] o1);
    req0_valid_i = v0; req0_r1_i = a0; req0_r2_i = b0; req0_op_i = o0;
    req1_valid_i = v1; req1_r1_i = a1; req1_r2_i = b1; req1_op_i = o1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst_ni = 1'b0;
    rsp_ready_i = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 16'h0, 16'h0, 4'h0);
    nextCycle();
    nextCycle();
    nVec++; if (rsp_valid_o !== 1'b0) begin nErr++; $display("[TB] FAIL reset_rsp_valid: got %h want 0", rsp_valid_o); end
    nVec++; if (busy_o !== 1'b0) begin nErr++; $display("[TB] FAIL reset_busy: got %h want 0", busy_o); end
    nVec++; if (rsp_id_o !== 1'b0) begin nErr++; $display("[TB] FAIL reset_rsp_id: got %h want 0", rsp_id_o); end
    nVec++; if (rsp_data_o !== 16'h0000) begin nErr++; $display("[TB] FAIL reset_rsp_data: got %h want 0000", rsp_data_o); end
    nVec++; if (rsp_flags_o !== 4'h0) begin nErr++; $display("[TB] FAIL reset_rsp_flags: got %h want 0", rsp_flags_o); end
    nVec++; if ({alu_r1_o, alu_r2_o, alu_op_o} !== 36'h0) begin nErr++; $display("[TB] FAIL reset_alu_regs: got %h/%h/%h want 0/0/0", alu_r1_o, alu_r2_o, alu_op_o); end
  endtask

  task automatic test_basic_add();
    $display("[TB] test_basic_add");
    // Release reset and request in the very first cycle.
    rst_ni = 1'b1;
    applyStimulus(1'b1, 16'h0003, 16'hFFFE, 4'd0, 1'b0, 16'h0, 16'h0, 4'h0);
    #1;
    nVec++; if (req0_ready_o !== 1'b1) begin nErr++; $display("[TB] FAIL basic_ready0: got %h want 1", req0_ready_o); end
    nVec++; if (req1_ready_o !== 1'b0) begin nErr++; $display("[TB] FAIL basic_ready1: got %h want 0", req1_ready_o); end
    nextCycle();
    applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 16'h0, 16'h0, 4'h0);
    #1;
    nVec++; if (busy_o !== 1'b1) begin nErr++; $display("[TB] FAIL basic_exec_busy: got %h want 1", busy_o); end
    nVec++; if (rsp_valid_o !== 1'b0) begin nErr++; $display("[TB] FAIL basic_exec_rsp_valid: got %h want 0", rsp_valid_o); end
    nVec++; if ({alu_r1_o, alu_r2_o, alu_op_o} !== {16'h0003, 16'hFFFE, 4'd0}) begin nErr++; $display("[TB] FAIL basic_alu_regs: got %h/%h/%h want 0003/fffe/0", alu_r1_o, alu_r2_o, alu_op_o); end
    nextCycle();
    nVec++; if (rsp_valid_o !== 1'b1) begin nErr++; $display("[TB] FAIL basic_rsp_valid: got %h want 1", rsp_valid_o); end
    nVec++; if (rsp_id_o !== 1'b0) begin nErr++; $display("[TB] FAIL basic_rsp_id: got %h want 0", rsp_id_o); end
    nVec++; if (rsp_data_o !== 16'h0001) begin nErr++; $display("[TB] FAIL basic_rsp_data: got %h want 0001", rsp_data_o); end
    nVec++; if (rsp_flags_o !== 4'b0010) begin nErr++; $display("[TB] FAIL basic_rsp_flags: got %b want 0010", rsp_flags_o); end
    rsp_ready_i = 1'b1;
    nextCycle();
    nVec++; if (busy_o !== 1'b0) begin nErr++; $display("[TB] FAIL basic_idle_busy: got %h want 0", busy_o); end
    nVec++; if (rsp_valid_o !== 1'b0) begin nErr++; $display("[TB] FAIL basic_idle_rsp_valid: got %h want 0", rsp_valid_o); end
    nVec++; if (alu_r1_o !== 16'h0003) begin nErr++; $display("[TB] FAIL basic_alu_hold: got %h want 0003", alu_r1_o); end
  endtask

  task automatic test_back_to_back();
    logic expGrant;
    $display("[TB] test_back_to_back");
    rst_ni = 1'b0;
    nextCycle();
    rst_ni = 1'b1;
    rsp_ready_i = 1'b1;
    applyStimulus(1'b1, 16'h0010, 16'h0005, 4'd0, 1'b1, 16'h0100, 16'h0100, 4'd3);
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      expGrant = 1'b0;
`else
      expGrant = (i % 2) == 1;
`endif
      #1;
      nVec++; if ({req1_ready_o, req0_ready_o} !== {expGrant, ~expGrant}) begin nErr++; $display("[TB] FAIL rr_ready op%0d: got %b want %b", i, {req1_ready_o, req0_ready_o}, {expGrant, ~expGrant}); end
      nextCycle();
      nVec++; if (busy_o !== 1'b1) begin nErr++; $display("[TB] FAIL rr_exec_busy op%0d: got %h want 1", i, busy_o); end
      nextCycle();
      nVec++; if (rsp_valid_o !== 1'b1) begin nErr++; $display("[TB] FAIL rr_rsp_valid op%0d: got %h want 1", i, rsp_valid_o); end
      nVec++; if (rsp_id_o !== expGrant) begin nErr++; $display("[TB] FAIL rr_rsp_id op%0d: got %h want %h", i, rsp_id_o, expGrant); end
      nVec++; if ({rsp_data_o, rsp_flags_o} !== (expGrant ? {16'h0000, 4'b1000} : {16'h0015, 4'b0000})) begin nErr++; $display("[TB] FAIL rr_rsp_data op%0d: got %h/%b want %h", i, rsp_data_o, rsp_flags_o, expGrant ? 16'h0000 : 16'h0015); end
      nextCycle();
    end
    applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 16'h0, 16'h0, 4'h0);
  endtask

  task automatic test_backpressure();
    $display("[TB] test_backpressure");
    rsp_ready_i = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 16'h7FFF, 16'h0001, 4'd0);
    #1;
    nVec++; if (req1_ready_o !== 1'b1) begin nErr++; $display("[TB] FAIL bp_ready1: got %h want 1", req1_ready_o); end
    nextCycle();
    // Both requesters stay valid while the response is held.
    applyStimulus(1'b1, 16'h1111, 16'h2222, 4'd0, 1'b1, 16'h7FFF, 16'h0001, 4'd0);
    nextCycle();
    for (int i = 0; i < 5; i++) begin
      nVec++; if (rsp_valid_o !== 1'b1) begin nErr++; $display("[TB] FAIL bp_rsp_valid c%0d: got %h want 1", i, rsp_valid_o); end
      nVec++; if ({rsp_id_o, rsp_data_o, rsp_flags_o} !== {1'b1, 16'h8000, 4'b0101}) begin nErr++; $display("[TB] FAIL bp_rsp_hold c%0d: got %h/%h/%b want 1/8000/0101", i, rsp_id_o, rsp_data_o, rsp_flags_o); end
      nVec++; if ({req0_ready_o, req1_ready_o} !== 2'b00) begin nErr++; $display("[TB] FAIL bp_readies c%0d: got %b want 00", i, {req0_ready_o, req1_ready_o}); end
      nVec++; if (busy_o !== 1'b1) begin nErr++; $display("[TB] FAIL bp_busy c%0d: got %h want 1", i, busy_o); end
      nextCycle();
    end
    applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 16'h0, 16'h0, 4'h0);
    rsp_ready_i = 1'b1;
    nextCycle();
    nVec++; if ({rsp_valid_o, busy_o} !== 2'b00) begin nErr++; $display("[TB] FAIL bp_release: got valid/busy %b want 00", {rsp_valid_o, busy_o}); end
  endtask

  task automatic test_reset_mid_exec();
    $display("[TB] test_reset_mid_exec");
    rsp_ready_i = 1'b1;
    applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 16'h4444, 16'h0004, 4'd0);
    #1;
    nVec++; if (req1_ready_o !== 1'b1) begin nErr++; $display("[TB] FAIL mid_ready1: got %h want 1", req1_ready_o); end
    nextCycle();
    nVec++; if (busy_o !== 1'b1) begin nErr++; $display("[TB] FAIL mid_exec_busy: got %h want 1", busy_o); end
    rst_ni = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 16'h0, 16'h0, 4'h0);
    #1;
    nVec++; if ({rsp_valid_o, busy_o} !== 2'b00) begin nErr++; $display("[TB] FAIL mid_reset_now: got valid/busy %b want 00", {rsp_valid_o, busy_o}); end
    nVec++; if (alu_r1_o !== 16'h0000) begin nErr++; $display("[TB] FAIL mid_reset_alu_r1: got %h want 0000", alu_r1_o); end
    nextCycle();
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      nVec++; if (rsp_valid_o !== 1'b0) begin nErr++; $display("[TB] FAIL mid_no_rsp c%0d: got %h want 0", i, rsp_valid_o); end
    end
    applyStimulus(1'b1, 16'h1234, 16'h1111, 4'd1, 1'b1, 16'h5555, 16'h5555, 4'd3);
    #1;
    nVec++; if ({req0_ready_o, req1_ready_o} !== 2'b10) begin nErr++; $display("[TB] FAIL mid_next_grant: got %b want 10", {req0_ready_o, req1_ready_o}); end
    nextCycle();
    applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 16'h0, 16'h0, 4'h0);
    nextCycle();
    nVec++; if ({rsp_valid_o, rsp_id_o, rsp_data_o, rsp_flags_o} !== {1'b1, 1'b0, 16'h0123, 4'b0000}) begin nErr++; $display("[TB] FAIL mid_sub_rsp: got %h/%h/%h/%b want 1/0/0123/0000", rsp_valid_o, rsp_id_o, rsp_data_o, rsp_flags_o); end
    nextCycle();
  endtask

  task automatic test_drop();
    $display("[TB] test_drop");
    rsp_ready_i = 1'b1;
    applyStimulus(1'b1, 16'h00AA, 16'h0F0F, 4'd2, 1'b0, 16'h0, 16'h0, 4'h0);
    #1;
    nVec++; if (req0_ready_o !== 1'b1) begin nErr++; $display("[TB] FAIL drop_ready0: got %h want 1", req0_ready_o); end
    nextCycle();
    // req1 appears during EXEC and is withdrawn before the FSM returns.
    applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 16'hBEEF, 16'h0001, 4'd0);
    #1;
    nVec++; if (req1_ready_o !== 1'b0) begin nErr++; $display("[TB] FAIL drop_ready1_exec: got %h want 0", req1_ready_o); end
    #2;
    req1_valid_i = 1'b0;
    nextCycle();
    nVec++; if ({rsp_valid_o, rsp_id_o, rsp_data_o} !== {1'b1, 1'b0, 16'h000A}) begin nErr++; $display("[TB] FAIL drop_rsp: got %h/%h/%h want 1/0/000a", rsp_valid_o, rsp_id_o, rsp_data_o); end
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      nVec++; if ({rsp_valid_o, busy_o, req1_ready_o} !== 3'b000) begin nErr++; $display("[TB] FAIL drop_quiet c%0d: got valid/busy/ready1 %b want 000", i, {rsp_valid_o, busy_o, req1_ready_o}); end
      nextCycle();
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_exec();
    test_drop();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
